// File: rtl/read_stride_fifo_if.sv
// Configuration, BRAM-read and downstream-stream signals of read_stride_fifo.
interface read_stride_fifo_if #(
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int LOG_MAX_ADDRESS        = 16
);
  logic                              configure;
  logic [LOG_MAX_ITERS-1:0]          num_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter;
  logic [LOG_MAX_ADDRESS-1:0]        base_address;
  logic [LOG_MAX_ADDRESS-1:0]        read_stride;
  logic [LOG_MAX_ADDRESS-1:0]        iter_stride;
  logic                              valid_in;
  logic [DATA_WIDTH-1:0]             data_in;
  logic [LOG_MAX_ADDRESS-1:0]        address_out;
  logic                              request;
  logic                              avail_in;
  logic                              valid_out;
  logic [DATA_WIDTH-1:0]             data_out;
  logic                              busy;
  logic                              done;
  logic [31:0]                       stall_count;

  modport master (
    output configure, num_iters, num_reads_per_iter, base_address, read_stride, iter_stride,
    output valid_in, data_in, avail_in,
    input  address_out, request, valid_out, data_out, busy, done, stall_count
  );

  modport slave (
    input  configure, num_iters, num_reads_per_iter, base_address, read_stride, iter_stride,
    input  valid_in, data_in, avail_in,
    output address_out, request, valid_out, data_out, busy, done, stall_count
  );
endinterface

// File: rtl/read_stride_fifo.sv
// 2-D strided BRAM reader with a credit-throttled return FIFO and busy/done reporting.
// Defining READ_STRIDE_STATS_EN adds the saturating downstream stall counter.
module read_stride_fifo #(
  parameter int    DATA_WIDTH             = 8,
  parameter int    LOG_MAX_ITERS          = 16,
  parameter int    LOG_MAX_READS_PER_ITER = 16,
  parameter int    LOG_MAX_ADDRESS        = 16,
  parameter int    FIFO_DEPTH             = 4,
  parameter int    LOG_FIFO_DEPTH         = 2,
  parameter string TYPE                   = "unspecified"
) (
  input logic               clk,
  input logic               rst,
  read_stride_fifo_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [LOG_FIFO_DEPTH:0]         FULL_CREDITS = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG_FIFO_DEPTH:0]         PTR_ONE      = (LOG_FIFO_DEPTH+1)'(1);
  localparam logic [LOG_MAX_ITERS-1:0]        ITER_ONE     = LOG_MAX_ITERS'(1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE   = LOG_MAX_READS_PER_ITER'(1);

  state_t                            state;
  logic [LOG_MAX_ITERS-1:0]          iters_left;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_left, reads_cfg;
  logic [LOG_MAX_ADDRESS-1:0]        read_stride_q, iter_stride_q, cur_addr, row_base, address_q;
  logic                              request_q, busy_q, done_q;
  logic [LOG_FIFO_DEPTH:0]           credits, outstanding, wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]             mem [FIFO_DEPTH];
  logic                              empty, full, issue, push, pop, accept;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[LOG_FIFO_DEPTH] != rd_ptr[LOG_FIFO_DEPTH]) &&
                  (wr_ptr[LOG_FIFO_DEPTH-1:0] == rd_ptr[LOG_FIFO_DEPTH-1:0]);
  assign issue  = (state == RUN) && (credits != '0);
  // Returns with nothing outstanding belong to a request issued before reset.
  assign push   = io.valid_in && (outstanding != '0);
  assign pop    = ~empty & io.avail_in;
  assign accept = (state == IDLE) && io.configure;

  assign io.valid_out   = pop;
  assign io.data_out    = mem[rd_ptr[LOG_FIFO_DEPTH-1:0]];
  assign io.request     = request_q;
  assign io.address_out = address_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[LOG_FIFO_DEPTH-1:0]] <= io.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      request_q     <= 1'b0;
      address_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      credits       <= FULL_CREDITS;
      outstanding   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      iters_left    <= '0;
      reads_left    <= '0;
      reads_cfg     <= '0;
      read_stride_q <= '0;
      iter_stride_q <= '0;
      cur_addr      <= '0;
      row_base      <= '0;
    end else begin
      request_q <= issue;
      done_q    <= 1'b0;
      if (issue) address_q <= cur_addr;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (issue && !pop)      credits <= credits - PTR_ONE;
      else if (!issue && pop) credits <= credits + PTR_ONE;
      if (issue && !push)      outstanding <= outstanding + PTR_ONE;
      else if (!issue && push) outstanding <= outstanding - PTR_ONE;

      case (state)
        IDLE: if (accept) begin
          iters_left    <= io.num_iters;
          reads_left    <= io.num_reads_per_iter;
          reads_cfg     <= io.num_reads_per_iter;
          read_stride_q <= io.read_stride;
          iter_stride_q <= io.iter_stride;
          cur_addr      <= io.base_address;
          row_base      <= io.base_address;
          busy_q        <= 1'b1;
          state <= (io.num_iters != '0 && io.num_reads_per_iter != '0) ? RUN : DONE;
        end
        RUN: if (issue) begin
          if (reads_left != READ_ONE) begin
            cur_addr   <= cur_addr + read_stride_q;
            reads_left <= reads_left - READ_ONE;
          end else if (iters_left != ITER_ONE) begin
            row_base   <= row_base + iter_stride_q;
            cur_addr   <= row_base + iter_stride_q;
            reads_left <= reads_cfg;
            iters_left <= iters_left - ITER_ONE;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: if (credits == FULL_CREDITS) state <= DONE;
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef READ_STRIDE_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst)                                                       stall_q <= '0;
    else if (accept)                                               stall_q <= '0;
    else if (busy_q && !empty && !io.avail_in && stall_q != '1)    stall_q <= stall_q + 32'd1;
  end
  assign io.stall_count = stall_q;
`else
  assign io.stall_count = 32'd0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && io.configure && state != IDLE)
      $display("%s: configure ignored while busy", TYPE);
    if (!rst)
      assert (!(push && full && !pop)) else $error("%s: return data overflowed the FIFO", TYPE);
  end
`endif
endmodule

// File: doc/read_stride_fifo.md
Name: read_stride_fifo

Overview:
Parametrised successor of the block-RAM read stage. It issues BRAM read requests over a 2-D address pattern: per-read stride, plus a per-iteration base offset. Returned data is buffered in a configurable-depth FIFO and forwarded to the downstream module under the avail_in/valid_out handshake. Credit-based request throttling tolerates arbitrary BRAM read latency without FIFO overflow, and the block reports busy/done to the layer controller.

Parameters:
DATA_WIDTH, 8, data word width
LOG_MAX_ITERS, 16, width of iteration counter
LOG_MAX_READS_PER_ITER, 16, width of reads-per-iteration counter
LOG_MAX_ADDRESS, 16, BRAM address width
FIFO_DEPTH, 4, FIFO slots (>=2, power of two)
LOG_FIFO_DEPTH, 2, log2(FIFO_DEPTH)
TYPE, "unspecified", instance tag used in debug prints

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
configure  in  1  one-cycle configuration strobe
num_iters  in  LOG_MAX_ITERS  iteration count
num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  reads per iteration
base_address  in  LOG_MAX_ADDRESS  first address
read_stride  in  LOG_MAX_ADDRESS  address increment between reads in an iteration
iter_stride  in  LOG_MAX_ADDRESS  base increment between iterations (0 = repeat same block)
valid_in  in  1  BRAM data valid
data_in  in  DATA_WIDTH  BRAM data
address_out  out  LOG_MAX_ADDRESS  BRAM read address (registered)
request  out  1  BRAM read request (registered)
avail_in  in  1  downstream ready
valid_out  out  1  forward strobe
data_out  out  DATA_WIDTH  FIFO head
busy  out  1  high from accepted configure until done
done  out  1  one-cycle completion pulse
stall_count  out  32  see Optional Feature

Behaviour:
- Reset (rst=1 at posedge): state IDLE. request=0, address_out=0, busy=0, done=0, FIFO empty (valid_out=0), credits=FIFO_DEPTH, stall_count=0. Reset mid-operation aborts immediately and drops FIFO contents and outstanding requests. BRAM data arriving after reset is ignored; valid_in is masked for BRAM latency cycles, tracked by the outstanding counter being 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + configure: latch all config inputs; cur_addr=row_base=base_address; busy=1 next cycle.
  - Next state RUN if num_iters!=0 and num_reads_per_iter!=0.
  - Otherwise next state DONE with no requests.
- configure while busy: ignored. Simulation-only $display warning.
- Issue condition (comb): state==RUN and credits!=0.
  - On issue, the next cycle sees request=1 and address_out=cur_addr. Otherwise request=0; address_out holds its value.
  - Credits decrement on issue and increment on FIFO pop. Simultaneous issue+pop leaves credits unchanged.
  - Invariant: FIFO occupancy + outstanding <= FIFO_DEPTH, so valid_in never hits a full FIFO. A sim assertion fires if it does.
- Address update on issue:
  - If reads remain in the row: cur_addr += read_stride, reads_left -= 1.
  - At row end with iters_left>1: row_base += iter_stride, cur_addr = new row_base, reads reloaded, iters_left -= 1.
  - At last read of last iteration: go to DRAIN.
  - All address arithmetic is modulo 2^LOG_MAX_ADDRESS (silent wrap).
- valid_in pushes data_in into the FIFO; any BRAM latency >=1 cycle is supported.
- Forward (comb): valid_out = ~empty & avail_in; data_out = FIFO head; pop when valid_out. Zero-latency pass of head; ordering equals request order.
- Simultaneous push and pop on the same cycle is allowed at any occupancy, including empty (data appears the following cycle) and full.
- DRAIN: no requests issued. Leave when credits==FIFO_DEPTH (all data returned and forwarded) -> DONE.
- DONE: done=1 for exactly one cycle, busy falls the same cycle done rises, next state IDLE. A configure in the DONE cycle is ignored.
- Total requests per configuration = num_iters*num_reads_per_iter, exactly.

Optional Feature:
READ_STRIDE_STATS_EN.
- Defined: stall_count increments each cycle with ~empty & ~avail_in while busy. It clears on accepted configure and saturates at 2^32-1.
- Undefined: no counter logic; stall_count tied to 0.

Test Plan:
- base=0x10, read_stride=1, iter_stride=0, iters=2, reads=3, avail_in=1, latency 1 -> addresses 10,11,12,10,11,12; 6 valid_out in order; done pulses once; busy low after.
- base=0x100, read_stride=4, iter_stride=0x20, iters=3, reads=2 -> addresses 100,104,120,124,140,144.
- FIFO_DEPTH=4, avail_in=0 throughout, latency 3 -> exactly 4 requests then request stays 0; raising avail_in resumes; no overflow assertion.
- base=0xFFFE, read_stride=1, iters=1, reads=4 -> addresses FFFE,FFFF,0000,0001.
- iters=0 -> no request; done pulses 2 cycles after configure; configure pulsed mid-RUN is ignored and the sequence is unchanged.
- rst asserted mid-RUN with 2 entries in the FIFO -> next cycle valid_out=0, request=0, busy=0; a new configure runs cleanly. With READ_STRIDE_STATS_EN, 5 stall cycles -> stall_count=5.
